w29ee_prog_sequencer: RTL
=========================

Name: w29ee_prog_sequencer

Overview:
- Hardware sequencer for JEDEC-style parallel flash page programming (W29EE011 class, 17-bit address, 8-bit data), clocked from the 24 MHz oscillator.
- On start it replays the JEDEC unlock/command buffer onto the DUT bus, then streams the payload buffer from the start address. It then runs DQ7 data polling until the page write completes or times out.
- Sits between the microcontroller register file (buffers, start address, run command) and the ZIF pin drivers. This replaces the fixed software delay with hardware completion detection.

Parameters:
- ADDR_W, 17, DUT address width.
- WBUF_AW, 8, payload index/count width.
- JBUF_AW, 3, JEDEC buffer index/count width.
- WE_CYCLES, 24, #WE low pulse width in clocks (1 us).
- HOLD_CYCLES, 24, #WE high time between writes and before polling, in clocks.
- OE_CYCLES, 6, #OE low time per poll read; sampling happens on the last cycle.
- TIMEOUT_POLLS, 16'd8400, maximum poll reads before the error is flagged.

Ports:
- osc  in  1  24 MHz clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle run request; accepted only in IDLE.
- busy  out  1  high from the cycle after an accepted start until DONE/ERR exits.
- done  out  1  one-cycle pulse on successful completion.
- timeout_err  out  1  sticky; cleared by the next accepted start.
- prog_addr  in  ADDR_W  payload start address; sampled at start.
- jedec_count  in  JBUF_AW  number of JEDEC entries; sampled at start.
- wbuf_count  in  WBUF_AW  number of payload bytes; sampled at start.
- jedec_idx  out  JBUF_AW  JEDEC buffer read index.
- jedec_addr  in  ADDR_W  JEDEC entry address; combinational from jedec_idx.
- jedec_data  in  8  JEDEC entry data; combinational from jedec_idx.
- wbuf_idx  out  WBUF_AW  payload buffer read index.
- wbuf_data  in  8  payload byte; combinational from wbuf_idx.
- dut_addr  out  ADDR_W  DUT address bus.
- dut_dout  out  8  DUT write data.
- dut_doe  out  1  1 = FPGA drives DQ lines.
- dut_ce_n  out  1  DUT #CE.
- dut_oe_n  out  1  DUT #OE.
- dut_we_n  out  1  DUT #WE.
- dut_din  in  8  DQ lines as read back from the DUT.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-operation):
  - state=IDLE; busy=0, done=0, timeout_err=0.
  - dut_ce_n=dut_oe_n=dut_we_n=1, dut_doe=0.
  - dut_addr=0, dut_dout=0, both indices 0, all counters 0.
- States: IDLE, J_SET, J_WE, J_HOLD, P_SET, P_WE, P_HOLD, POLL_OE, POLL_GAP, DONE, ERR.
- Delay counter: loaded with N-1 on state entry; the state exits on the cycle the counter reads 0.
- IDLE:
  - On start, latch the counts and prog_addr, zero both indices, clear timeout_err, set busy=1, drive dut_ce_n=0.
  - Go to J_SET if jedec_count!=0, else P_SET if wbuf_count!=0, else DONE.
- J_SET (1 cycle):
  - dut_addr=jedec_addr, dut_dout=jedec_data, dut_doe=1.
  - Then J_WE.
- J_WE (WE_CYCLES): dut_we_n=0. On exit, set dut_we_n=1 and jedec_idx+1, then J_HOLD.
- J_HOLD (HOLD_CYCLES):
  - If jedec_idx==jedec_count, go to P_SET if wbuf_count!=0, else DONE.
  - Otherwise go to J_SET.
- P_SET (1 cycle): dut_addr=running address (prog_addr at first entry), dut_dout=wbuf_data, dut_doe=1.
- P_WE (WE_CYCLES):
  - dut_we_n=0; on exit dut_we_n=1.
  - Latch last_bit7=dut_dout[7].
  - wbuf_idx+1; running address +1, modulo 2^ADDR_W (wraps 1FFFF→0).
- P_HOLD (HOLD_CYCLES): if wbuf_idx==wbuf_count, go to POLL_OE with dut_doe=0 and poll_cnt=0; else P_SET.
- Poll addressing: dut_addr stays at the last written address (running address - 1, mod 2^ADDR_W).
- POLL_OE (OE_CYCLES):
  - dut_oe_n=0.
  - On the last cycle, sample dut_din[7], set dut_oe_n=1, poll_cnt+1.
  - If sample==last_bit7, go to DONE.
  - Else if poll_cnt+1==TIMEOUT_POLLS, go to ERR.
  - Else go to POLL_GAP.
- POLL_GAP (HOLD_CYCLES): then POLL_OE.
- DONE (1 cycle): done=1, busy=0, dut_ce_n=1, then IDLE.
- ERR (1 cycle): timeout_err=1, busy=0, dut_ce_n=1, then IDLE.
- dut_doe and dut_oe_n are never low simultaneously (bus-contention invariant).
- start while busy is ignored and has no effect.
- A count of 0 means zero entries. Full-scale counts are jedec_count 7 and wbuf_count 255.
- Index comparisons use equality, so counts never overflow their widths.

Decomposition:
- Shared package w29ee_pkg: state enum, ADDR_W/WBUF_AW/JBUF_AW constants, default timing constants derived from the 24 MHz clock (CLK_PER_US=24).
- One sub-module, prog_delay_counter: a loadable down-counter with a zero flag, reused for the WE, HOLD, OE and GAP delays.
- The FSM stays in w29ee_prog_sequencer.

Test Plan:
- Page write: jedec={5555/AA, 2AAA/55, 5555/A0}, wbuf = 4 bytes {12,34,56,F8} at 00100; DUT model flips DQ7 after 3 polls.
  - Required: 7 #WE pulses, each 24 clocks low, at addresses 5555, 2AAA, 5555, 00100..00103.
  - Required: polls at 00103; done pulse after the 4th poll; timeout_err=0.
- Erase-style command: jedec_count=6, wbuf_count=0 → 6 #WE pulses, no #OE activity, done asserted in the cycle after the last J_HOLD.
- Address wrap: prog_addr=1FFFE, wbuf_count=3 → writes at 1FFFE, 1FFFF, 00000; polling at 00000.
- Timeout: TIMEOUT_POLLS=5, DUT never matches → exactly 5 #OE pulses, then timeout_err=1 and busy=0.
  - A following start clears timeout_err in the cycle after acceptance.
- Reset mid-P_WE: deassert rst_n while dut_we_n=0 → dut_we_n, dut_ce_n and dut_oe_n go to 1 and busy to 0 asynchronously. A start after release replays from jedec entry 0.
- Throughout all scenarios: start pulses while busy are ignored, and the assertion that dut_doe & !dut_oe_n never holds.

Source files
------------

// File: rtl/w29ee_pkg.sv
// Shared types and default constants for the W29EE011 page-program sequencer.
package w29ee_pkg;

  localparam int unsigned ADDR_W_DEF  = 17;
  localparam int unsigned WBUF_AW_DEF = 8;
  localparam int unsigned JBUF_AW_DEF = 3;

  // Timing defaults derived from the 24 MHz oscillator
  localparam int unsigned CLK_PER_US        = 24;
  localparam int unsigned WE_CYCLES_DEF     = CLK_PER_US;
  localparam int unsigned HOLD_CYCLES_DEF   = CLK_PER_US;
  localparam int unsigned OE_CYCLES_DEF     = CLK_PER_US / 4;
  localparam logic [15:0] TIMEOUT_POLLS_DEF = 16'd8400;

  // Width of the shared delay counter
  localparam int unsigned DLY_W = 16;

  typedef enum logic [3:0] {
    S_IDLE,
    S_J_SET,
    S_J_WE,
    S_J_HOLD,
    S_P_SET,
    S_P_WE,
    S_P_HOLD,
    S_POLL_OE,
    S_POLL_GAP,
    S_DONE,
    S_ERR
  } state_t;

endpackage

// File: rtl/w29ee_prog_sequencer_prog_delay_counter.sv
// Loadable down-counter with a zero flag; shared by the WE, HOLD, OE and GAP delays.
module prog_delay_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  // Load on request, otherwise count down and park at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/w29ee_prog_sequencer.sv
// JEDEC unlock replay, payload streaming and DQ7 data polling for W29EE011-class flash.
module w29ee_prog_sequencer
  import w29ee_pkg::*;
#(
  parameter int unsigned ADDR_W        = ADDR_W_DEF,
  parameter int unsigned WBUF_AW       = WBUF_AW_DEF,
  parameter int unsigned JBUF_AW       = JBUF_AW_DEF,
  parameter int unsigned WE_CYCLES     = WE_CYCLES_DEF,
  parameter int unsigned HOLD_CYCLES   = HOLD_CYCLES_DEF,
  parameter int unsigned OE_CYCLES     = OE_CYCLES_DEF,
  parameter logic [15:0] TIMEOUT_POLLS = TIMEOUT_POLLS_DEF
) (
  input  logic               osc,
  input  logic               rst_n,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               timeout_err,
  input  logic [ADDR_W-1:0]  prog_addr,
  input  logic [JBUF_AW-1:0] jedec_count,
  input  logic [WBUF_AW-1:0] wbuf_count,
  output logic [JBUF_AW-1:0] jedec_idx,
  input  logic [ADDR_W-1:0]  jedec_addr,
  input  logic [7:0]         jedec_data,
  output logic [WBUF_AW-1:0] wbuf_idx,
  input  logic [7:0]         wbuf_data,
  output logic [ADDR_W-1:0]  dut_addr,
  output logic [7:0]         dut_dout,
  output logic               dut_doe,
  output logic               dut_ce_n,
  output logic               dut_oe_n,
  output logic               dut_we_n,
  input  logic [7:0]         dut_din
);

  localparam logic [DLY_W-1:0] WE_LD   = DLY_W'(WE_CYCLES - 1);
  localparam logic [DLY_W-1:0] HOLD_LD = DLY_W'(HOLD_CYCLES - 1);
  localparam logic [DLY_W-1:0] OE_LD   = DLY_W'(OE_CYCLES - 1);

  state_t             r_state;
  logic               r_busy, r_done, r_terr;
  logic               r_ce_n, r_oe_n, r_we_n, r_doe;
  logic [ADDR_W-1:0]  r_addr, r_run_addr;
  logic [7:0]         r_dout;
  logic [JBUF_AW-1:0] r_jidx, r_jcnt;
  logic [WBUF_AW-1:0] r_widx, r_wcnt;
  logic               r_last7;
  logic [15:0]        r_poll_cnt;

  logic               w_dly_load, w_dly_zero;
  logic [DLY_W-1:0]   w_dly_val;
  logic [15:0]        w_poll_nxt;
  logic               w_unused_din;

  assign w_poll_nxt   = r_poll_cnt + 16'd1;
  assign w_unused_din = ^dut_din[6:0];

  prog_delay_counter #(.W(DLY_W)) u_dly (
    .clk        (osc),
    .rst_n      (rst_n),
    .i_load     (w_dly_load),
    .i_load_val (w_dly_val),
    .o_zero     (w_dly_zero)
  );

  // Reload the delay counter with N-1 for whichever timed state comes next
  always_comb begin
    w_dly_load = w_dly_zero;
    w_dly_val  = '0;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: w_dly_load = 1'b1;
      S_J_SET, S_P_SET: begin
        w_dly_load = 1'b1;
        w_dly_val  = WE_LD;
      end
      S_J_WE, S_P_WE, S_POLL_OE: w_dly_val = HOLD_LD;
      S_P_HOLD: if (r_widx == r_wcnt) w_dly_val = OE_LD;
      S_POLL_GAP: w_dly_val = OE_LD;
      default: w_dly_val = '0;
    endcase
  end

  // Sequencer FSM with registered bus and status outputs
  always_ff @(posedge osc or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_terr     <= 1'b0;
      r_ce_n     <= 1'b1;
      r_oe_n     <= 1'b1;
      r_we_n     <= 1'b1;
      r_doe      <= 1'b0;
      r_addr     <= '0;
      r_run_addr <= '0;
      r_dout     <= '0;
      r_jidx     <= '0;
      r_jcnt     <= '0;
      r_widx     <= '0;
      r_wcnt     <= '0;
      r_last7    <= 1'b0;
      r_poll_cnt <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (start) begin
          r_jcnt     <= jedec_count;
          r_wcnt     <= wbuf_count;
          r_run_addr <= prog_addr;
          r_jidx     <= '0;
          r_widx     <= '0;
          r_terr     <= 1'b0;
          r_busy     <= 1'b1;
          r_ce_n     <= 1'b0;
          if (jedec_count != '0) begin
            r_state <= S_J_SET;
          end else if (wbuf_count != '0) begin
            r_state <= S_P_SET;
          end else begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_J_SET: begin
          r_addr  <= jedec_addr;
          r_dout  <= jedec_data;
          r_doe   <= 1'b1;
          r_we_n  <= 1'b0;
          r_state <= S_J_WE;
        end
        S_J_WE: if (w_dly_zero) begin
          r_we_n  <= 1'b1;
          r_jidx  <= r_jidx + 1'b1;
          r_state <= S_J_HOLD;
        end
        S_J_HOLD: if (w_dly_zero) begin
          if (r_jidx != r_jcnt) begin
            r_state <= S_J_SET;
          end else if (r_wcnt != '0) begin
            r_state <= S_P_SET;
          end else begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_P_SET: begin
          r_addr  <= r_run_addr;
          r_dout  <= wbuf_data;
          r_doe   <= 1'b1;
          r_we_n  <= 1'b0;
          r_state <= S_P_WE;
        end
        S_P_WE: if (w_dly_zero) begin
          r_we_n     <= 1'b1;
          r_last7    <= r_dout[7];
          r_widx     <= r_widx + 1'b1;
          r_run_addr <= r_run_addr + 1'b1;
          r_state    <= S_P_HOLD;
        end
        S_P_HOLD: if (w_dly_zero) begin
          if (r_widx == r_wcnt) begin
            // Release DQ in the same edge that opens #OE: never both active
            r_doe      <= 1'b0;
            r_oe_n     <= 1'b0;
            r_poll_cnt <= '0;
            r_state    <= S_POLL_OE;
          end else begin
            r_state <= S_P_SET;
          end
        end
        S_POLL_OE: if (w_dly_zero) begin
          r_oe_n     <= 1'b1;
          r_poll_cnt <= w_poll_nxt;
          if (dut_din[7] == r_last7) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else if (w_poll_nxt == TIMEOUT_POLLS) begin
            r_state <= S_ERR;
            r_terr  <= 1'b1;
          end else begin
            r_state <= S_POLL_GAP;
          end
        end
        S_POLL_GAP: if (w_dly_zero) begin
          r_oe_n  <= 1'b0;
          r_state <= S_POLL_OE;
        end
        S_DONE, S_ERR: begin
          r_busy  <= 1'b0;
          r_ce_n  <= 1'b1;
          r_doe   <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign timeout_err = r_terr;
  assign jedec_idx   = r_jidx;
  assign wbuf_idx    = r_widx;
  assign dut_addr    = r_addr;
  assign dut_dout    = r_dout;
  assign dut_doe     = r_doe;
  assign dut_ce_n    = r_ce_n;
  assign dut_oe_n    = r_oe_n;
  assign dut_we_n    = r_we_n;

endmodule
